// File: rtl/quad_pkg.sv
// Shared state and quadrant-code definitions for the quadrant sequencer and the
// VGA highlight comparator.
package quad_pkg;

   typedef enum logic [1:0] {IDLE, BROWSE, LOCK, WIN} state_e;

   typedef logic [2:0] quad_t;

   localparam quad_t Q_NONE = 3'b000;
   localparam quad_t Q_TL   = 3'b001;
   localparam quad_t Q_TR   = 3'b010;
   localparam quad_t Q_BL   = 3'b011;
   localparam quad_t Q_BR   = 3'b100;

   function automatic quad_t quad_fwd(input quad_t q);
      return (q == Q_BR) ? Q_TL : quad_t'(q + 3'd1);
   endfunction

   function automatic quad_t quad_bwd(input quad_t q);
      return (q == Q_TL) ? Q_BR : quad_t'(q - 3'd1);
   endfunction

endpackage

// File: rtl/quadrant_sequencer_if.sv
// Button/frame inputs and comparator-facing outputs of the quadrant sequencer.
interface quadrant_sequencer_if;
   import quad_pkg::*;

   logic  frame_tick;
   logic  btn_next;
   logic  btn_prev;
   logic  btn_sel;
   logic  btn_clr;
   logic  win;
   quad_t quad_out;
   logic  sel_pulse;
   quad_t sel_quad;
   logic  busy;

   modport master (
      output frame_tick, btn_next, btn_prev, btn_sel, btn_clr, win,
      input  quad_out, sel_pulse, sel_quad, busy
   );

   modport slave (
      input  frame_tick, btn_next, btn_prev, btn_sel, btn_clr, win,
      output quad_out, sel_pulse, sel_quad, busy
   );

endinterface

// File: rtl/frame_timer.sv
// Saturating down-counter of frame ticks; done marks the count being zero or
// reaching zero on this cycle's tick.
module frame_timer #(
   parameter int unsigned LOAD_VAL = 60
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic tick,
   output logic done
);

   localparam int unsigned W = $clog2(LOAD_VAL) + 1;
   localparam logic [W-1:0] LoadCnt = W'(LOAD_VAL);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = LoadCnt;
      end else if (tick && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = (cnt_q == '0) || (tick && (cnt_q == W'(1)));

endmodule

// File: rtl/quadrant_sequencer.sv
// Cursor/select/lock controller for the quadrant highlight; quad_out only moves on
// frame boundaries, except that WIN and reset blank it at once.
module quadrant_sequencer
   import quad_pkg::*;
#(
   parameter int unsigned BLINK_FRAMES        = 30,
   parameter int unsigned LOCK_FRAMES         = 60,
   parameter int unsigned IDLE_TIMEOUT_FRAMES = 600
) (
   input logic                 clk,
   input logic                 rst_n,
   quadrant_sequencer_if.slave bus
);

   state_e state_q, state_d;
   quad_t  cur_q, cur_d;
   quad_t  sel_quad_q, sel_quad_d;
   quad_t  quad_out_q, quad_out_d;
   quad_t  disp;
   logic   sel_pulse_q;
   logic   phase_q, phase_d;
   logic   sel_accept;
   logic   any_btn, step_fwd, step_bwd;
   logic   lock_done, blink_done, idle_done;
   logic   lock_tick, idle_tick, blink_load, idle_load;

   assign any_btn  = bus.btn_next | bus.btn_prev | bus.btn_sel | bus.btn_clr;
   // Simultaneous next and prev cancel each other.
   assign step_fwd = bus.btn_next & ~bus.btn_prev;
   assign step_bwd = bus.btn_prev & ~bus.btn_next;

   assign lock_tick  = bus.frame_tick && (state_q == LOCK);
   assign idle_tick  = bus.frame_tick && (state_q == BROWSE);
   assign blink_load = sel_accept || ((state_q == LOCK) && blink_done);
   // Held at full scale outside BROWSE so every entry starts a fresh timeout.
   assign idle_load  = any_btn || (state_q != BROWSE);

   frame_timer #(.LOAD_VAL(LOCK_FRAMES)) u_lock_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (sel_accept),
      .tick  (lock_tick),
      .done  (lock_done)
   );

   frame_timer #(.LOAD_VAL(BLINK_FRAMES)) u_blink_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (blink_load),
      .tick  (lock_tick),
      .done  (blink_done)
   );

   frame_timer #(.LOAD_VAL(IDLE_TIMEOUT_FRAMES)) u_idle_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (idle_load),
      .tick  (idle_tick),
      .done  (idle_done)
   );

   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      sel_quad_d = sel_quad_q;
      phase_d    = phase_q;
      sel_accept = 1'b0;
      if (bus.win) begin
         state_d = WIN;
      end else if (state_q == WIN) begin
         state_d = IDLE;
         cur_d   = Q_TL;
      end else if (bus.btn_clr) begin
         state_d = IDLE;
         cur_d   = Q_TL;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (step_fwd) begin
                  state_d = BROWSE;
                  cur_d   = Q_TL;
               end else if (step_bwd) begin
                  state_d = BROWSE;
                  cur_d   = Q_BR;
               end
            end
            BROWSE: begin
               if (bus.btn_sel) begin
                  sel_accept = 1'b1;
                  sel_quad_d = cur_q;
                  phase_d    = 1'b1;
                  state_d    = LOCK;
               end else if (step_fwd) begin
                  cur_d = quad_fwd(cur_q);
               end else if (step_bwd) begin
                  cur_d = quad_bwd(cur_q);
               end else if (!any_btn && idle_done) begin
                  state_d = IDLE;
               end
            end
            LOCK: begin
               if (blink_done) begin
                  phase_d = ~phase_q;
               end
               if (lock_done) begin
                  state_d = BROWSE;
               end
            end
            default: ;
         endcase
      end
   end

   // Display is sampled from the post-button state so a coincident tick shows it.
   always_comb begin
      disp = Q_NONE;
      unique case (state_d)
         BROWSE:  disp = cur_d;
         LOCK:    disp = phase_d ? sel_quad_d : Q_NONE;
         default: disp = Q_NONE;
      endcase
      quad_out_d = quad_out_q;
      if (state_d == WIN) begin
         quad_out_d = Q_NONE;
      end else if (bus.frame_tick) begin
         quad_out_d = disp;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cur_q       <= Q_TL;
         sel_quad_q  <= Q_NONE;
         quad_out_q  <= Q_NONE;
         sel_pulse_q <= 1'b0;
         phase_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         sel_quad_q  <= sel_quad_d;
         quad_out_q  <= quad_out_d;
         sel_pulse_q <= sel_accept;
         phase_q     <= phase_d;
      end
   end

   assign bus.quad_out  = quad_out_q;
   assign bus.sel_pulse = sel_pulse_q;
   assign bus.sel_quad  = sel_quad_q;
   assign bus.busy      = (state_q == LOCK);

endmodule

// File: tb/tb_quadrant_sequencer.sv
// Scoreboard bench: a behavioural model queues expected outputs per cycle and per
// select event; a monitor pops and compares what the sequencer presents.
module tb_quadrant_sequencer;

   localparam int BLINK_F = 2;
   localparam int LOCK_F  = 6;
   localparam int IDLE_F  = 4;

   localparam int MIdle   = 0;
   localparam int MBrowse = 1;
   localparam int MLock   = 2;
   localparam int MWin    = 3;

   typedef struct {
      int q;
      int p;
      int s;
      int b;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic win_lvl = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   exp_t exp_q[$];
   int   sel_q[$];

   int m_mode, m_cur, m_sel, m_pulse, m_phase, m_lock, m_blink, m_idle, m_qout;

   always #5 clk = ~clk;

   quadrant_sequencer_if bus ();

   quadrant_sequencer #(
      .BLINK_FRAMES        (BLINK_F),
      .LOCK_FRAMES         (LOCK_F),
      .IDLE_TIMEOUT_FRAMES (IDLE_F)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic model_reset();
      m_mode  = MIdle;
      m_cur   = 1;
      m_sel   = 0;
      m_pulse = 0;
      m_phase = 1;
      m_lock  = 0;
      m_blink = 0;
      m_idle  = 0;
      m_qout  = 0;
   endtask

   task automatic model_step(input bit n, input bit p, input bit s, input bit c,
                             input bit w, input bit t);
      bit   any;
      int   disp;
      exp_t e;
      any     = n | p | s | c;
      m_pulse = 0;
      if (w) begin
         m_mode = MWin;
      end else if (m_mode == MWin) begin
         m_mode = MIdle;
         m_cur  = 1;
      end else if (c) begin
         m_mode = MIdle;
         m_cur  = 1;
      end else begin
         case (m_mode)
            MIdle: begin
               if (n && !p) begin
                  m_mode = MBrowse; m_cur = 1; m_idle = IDLE_F;
               end else if (p && !n) begin
                  m_mode = MBrowse; m_cur = 4; m_idle = IDLE_F;
               end
            end
            MBrowse: begin
               if (s) begin
                  m_sel = m_cur; m_pulse = 1; m_mode = MLock;
                  m_lock = LOCK_F; m_blink = BLINK_F; m_phase = 1;
               end else if (any) begin
                  m_idle = IDLE_F;
                  if (n && !p) m_cur = m_cur % 4 + 1;
                  else if (p && !n) m_cur = (m_cur + 2) % 4 + 1;
               end else if (t) begin
                  m_idle--;
                  if (m_idle == 0) m_mode = MIdle;
               end
            end
            MLock: begin
               if (t) begin
                  m_lock--;
                  m_blink--;
                  if (m_blink == 0) begin
                     m_phase = 1 - m_phase;
                     m_blink = BLINK_F;
                  end
                  if (m_lock == 0) begin
                     m_mode = MBrowse;
                     m_idle = IDLE_F;
                  end
               end
            end
            default: ;
         endcase
      end
      if (m_mode == MBrowse) disp = m_cur;
      else if (m_mode == MLock) disp = m_phase ? m_sel : 0;
      else disp = 0;
      if (m_mode == MWin) m_qout = 0;
      else if (t) m_qout = disp;
      e.q = m_qout;
      e.p = m_pulse;
      e.s = m_sel;
      e.b = (m_mode == MLock) ? 1 : 0;
      exp_q.push_back(e);
      if (m_pulse != 0) sel_q.push_back(m_sel);
   endtask

   task automatic drive(input bit n, input bit p, input bit s, input bit c, input bit t);
      @(negedge clk);
      bus.btn_next   = n;
      bus.btn_prev   = p;
      bus.btn_sel    = s;
      bus.btn_clr    = c;
      bus.frame_tick = t;
      bus.win        = win_lvl;
      model_step(n, p, s, c, win_lvl, t);
   endtask

   task automatic zero_inputs();
      bus.btn_next   = 1'b0;
      bus.btn_prev   = 1'b0;
      bus.btn_sel    = 1'b0;
      bus.btn_clr    = 1'b0;
      bus.frame_tick = 1'b0;
      win_lvl        = 1'b0;
      bus.win        = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_quad_out"}, int'(bus.quad_out), 0);
      check({tag, "_sel_pulse"}, int'(bus.sel_pulse), 0);
      check({tag, "_sel_quad"}, int'(bus.sel_quad), 0);
      check({tag, "_busy"}, int'(bus.busy), 0);
   endtask

   // Reset lands mid-cycle so the asynchronous clear is observed before any edge.
   task automatic async_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      zero_inputs();
      #1;
      check_reset_outputs("async_rst");
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("quad_out", int'(bus.quad_out), e.q);
            check("sel_pulse", int'(bus.sel_pulse), e.p);
            check("sel_quad", int'(bus.sel_quad), e.s);
            check("busy", int'(bus.busy), e.b);
         end
         if (bus.sel_pulse) begin
            check("sel_event_pending", (sel_q.size() > 0) ? 1 : 0, 1);
            if (sel_q.size() > 0) check("sel_event_quad", int'(bus.sel_quad), sel_q.pop_front());
         end
      end
   end

   initial begin : stimulus
      zero_inputs();
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // Entry from IDLE: quad_out waits for the tick.
      drive(1, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0);
      // Wrap in both directions, then cancelled next+prev.
      drive(0, 1, 0, 0, 0);
      drive(0, 0, 0, 0, 1);
      drive(1, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 1);
      drive(1, 1, 0, 0, 0);
      drive(0, 0, 0, 0, 1);
      // Select TR, blink through LOCK and return to BROWSE.
      drive(1, 0, 0, 0, 0);
      drive(0, 0, 1, 0, 0);
      drive(0, 0, 0, 0, 0);
      repeat (7) begin
         drive(0, 0, 0, 0, 1);
         drive(0, 1, 1, 0, 0);
      end
      // Idle timeout after IDLE_F ticks with no buttons.
      repeat (6) begin
         drive(0, 0, 0, 0, 1);
         drive(0, 0, 0, 0, 0);
      end
      // WIN in the middle of LOCK.
      drive(0, 1, 0, 0, 0);
      drive(0, 0, 1, 0, 0);
      drive(0, 0, 0, 0, 1);
      win_lvl = 1'b1;
      drive(1, 1, 1, 1, 0);
      drive(0, 0, 1, 0, 1);
      drive(1, 0, 0, 0, 0);
      win_lvl = 1'b0;
      drive(0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 1);
      // Clear beats select.
      drive(1, 0, 0, 0, 0);
      drive(0, 0, 1, 1, 0);
      drive(0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0);
      // Reset in the middle of LOCK.
      drive(1, 0, 0, 0, 0);
      drive(0, 0, 1, 0, 0);
      drive(0, 0, 0, 0, 1);
      async_reset();
      drive(0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0);

      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) async_reset();
         if ($urandom_range(0, 59) == 0) win_lvl = ~win_lvl;
         drive($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0,
               $urandom_range(0, 3) == 0);
      end
      win_lvl = 1'b0;
      drive(0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0);

      @(negedge clk);
      @(negedge clk);
      check("exp_queue_drained", exp_q.size(), 0);
      check("sel_queue_drained", sel_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/quadrant_sequencer.md
# quadrant_sequencer

Control block that decides which screen quadrant the VGA highlight comparator paints. Takes debounced one-cycle button pulses and a per-frame tick, moves a cursor over the four quadrants, and handles select/lock, clear, idle timeout and win blanking. Drives the comparator's 3-bit quadrant code so that changes land only on frame boundaries (no mid-frame tearing).

## Interface
- BLINK_FRAMES, 30: frames per blink half-period while LOCK.
- LOCK_FRAMES, 60: frames spent in LOCK after a select.
- IDLE_TIMEOUT_FRAMES, 600: frames without any button pulse before BROWSE returns to IDLE.
- clk  in  1  pixel-domain clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- frame_tick  in  1  one-cycle pulse per frame (start of vertical blank)
- btn_next  in  1  one-cycle pulse, cursor forward
- btn_prev  in  1  one-cycle pulse, cursor backward
- btn_sel  in  1  one-cycle pulse, select current quadrant
- btn_clr  in  1  one-cycle pulse, abort to IDLE
- win  in  1  game-won level; blanks highlight
- quad_out  out  3  quadrant code to comparator: 000 none, 001 TL, 010 TR, 011 BL, 100 BR
- sel_pulse  out  1  one-cycle pulse on accepted select
- sel_quad  out  3  last selected quadrant code, held
- busy  out  1  high in LOCK

## Operation
- States: IDLE, BROWSE, LOCK, WIN. Internal cursor cur in 1..4; displayed code disp (shadow of quad_out).
- Reset: state IDLE, cur=1, quad_out=000, sel_quad=000, sel_pulse=0, busy=0, all frame counters 0, blink phase on.
- IDLE: disp=000. btn_next -> BROWSE, cur=1; btn_prev -> BROWSE, cur=4. Other buttons ignored.
- BROWSE: disp=cur. btn_next: cur+1, 4 wraps to 1. btn_prev: cur-1, 1 wraps to 4. next and prev in same cycle: both ignored. btn_sel: sel_quad<=cur, sel_pulse=1 next cycle, -> LOCK, lock timer loaded LOCK_FRAMES, blink phase on. btn_sel has priority over next/prev in the same cycle.
- Idle timer: reloaded to IDLE_TIMEOUT_FRAMES on any button pulse or entry to BROWSE; decremented per frame_tick in BROWSE; reaching 0 -> IDLE.
- LOCK: next/prev/sel ignored. disp = sel_quad when blink phase on, 000 when off; phase toggles every BLINK_FRAMES frame_ticks. Lock timer decrements per frame_tick; at 0 -> BROWSE, cur unchanged, idle timer reloaded.
- btn_clr in IDLE/BROWSE/LOCK -> IDLE, cur=1; sel_quad retained. btn_clr beats btn_sel in the same cycle.
- win=1 in any state -> WIN (takes priority over all buttons). WIN: disp=000, all buttons ignored. win falling -> IDLE, cur=1.
- Counters saturate at 0; never wrap below 0. Widths sized by $clog2 of the parameter + 1.

## Timing
- State, cur, sel_quad, sel_pulse, busy update one cycle after the input pulse.
- quad_out loads disp only on the cycle after a frame_tick; between ticks it holds, even across state changes.
- Exception: entry to WIN or reset forces quad_out=000 on the next cycle / asynchronously, without waiting for frame_tick.
- frame_tick coincident with a button: button effect computed first, then disp sampled from the new state (new value visible one cycle after that tick).
- sel_pulse exactly one cycle wide; busy high from cycle after select until cycle after lock timer expires.
- Reset asserted mid-LOCK: all outputs return to reset values immediately; no sel_pulse on release.

## Structure
- Shared package quad_pkg: state enum (IDLE, BROWSE, LOCK, WIN), quadrant code constants Q_NONE=000, Q_TL=001, Q_TR=010, Q_BL=011, Q_BR=100; comparator uses the same constants.
- One sub-module: frame_timer (load value, decrement on frame_tick, done flag at zero); instantiated for lock, blink and idle timeout.

## Test plan
- Reset, btn_next, then frame_tick -> quad_out 000 until tick, 001 the cycle after tick.
- In BROWSE at cur=4, btn_next then tick -> quad_out 001; at cur=1, btn_prev then tick -> 100; next+prev same cycle -> unchanged.
- cur=2, btn_sel -> sel_pulse one cycle, sel_quad=010, busy=1; with BLINK_FRAMES=2, LOCK_FRAMES=6 quad_out alternates 010/000 every 2 ticks, BROWSE after 6 ticks with quad_out 010.
- BROWSE, IDLE_TIMEOUT_FRAMES=4, no buttons for 4 ticks -> IDLE, quad_out 000 after next tick.
- win asserted mid-LOCK -> quad_out 000 next cycle without tick, buttons ignored; win deasserted -> IDLE.
- btn_sel and btn_clr same cycle -> IDLE, no sel_pulse; rst_n low mid-LOCK -> all outputs zero immediately.
